// File: rtl/qtrline.sv
// QTR line sensor front end: debounces 8-bit samples and computes the signed line
// position as the mean of per-sensor weights. Exposed as a 4-register bus peripheral.
module qtrline (
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic       WE_I,
   input  logic       TGA_I,
   input  logic       STB_I,
   input  logic [7:0] ADR_I,
   input  logic [7:0] DAT_I,
   input  logic       samp_stb,
   input  logic [7:0] samp,
   output logic       STALL_O,
   output logic       ACK_O,
   output logic [7:0] DAT_O
);

   // state  | meaning
   // S_IDLE | waiting for a filtered change (req)
   // S_SUM  | weight sum and popcount of filtered
   // S_DIV  | 8 restoring-division steps, then sign fix-up
   // S_DONE | publish position, raise data_avail
   typedef enum logic [1:0] {S_IDLE, S_SUM, S_DIV, S_DONE} state_t;

   state_t      state_q, state_d;
   logic        req_q, req_d;
   logic [7:0]  filt_q, filt_d;
   logic [7:0]  cand_q, cand_d;
   logic [3:0]  stab_q, stab_d;
   logic        chk_q, chk_d;
   logic [7:0]  pos_q, pos_d;
   logic        avail_q, avail_d;
   logic [3:0]  deb_q, deb_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic [7:0]  quo_q, quo_d;
   logic [3:0]  rem_q, rem_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        neg_q, neg_d;
   logic [3:0]  step_q, step_d;

   logic        myaddr, reg_wr, reg_rd;
   logic [7:0]  s_c;
   logic        acc_c, upd_c, avail_set;
   logic [3:0]  deb_eff;
   logic signed [9:0] sum_c;
   logic [3:0]  cnt_c;
   logic [7:0]  mag_c;
   logic [4:0]  trial_c;

   assign myaddr  = STB_I && (ADR_I[7:2] == 6'd0);
   assign reg_wr  = myaddr && TGA_I && WE_I;
   assign reg_rd  = myaddr && TGA_I && !WE_I;
   assign STALL_O = 1'b0;
   assign ACK_O   = myaddr;

   always_comb begin
      DAT_O = DAT_I;
      if (myaddr) begin
         if (!TGA_I) begin
            DAT_O = avail_q ? 8'h02 : 8'h00;
         end else begin
            case (ADR_I[1:0])
               2'd0:    DAT_O = pos_q;
               2'd1:    DAT_O = filt_q;
               2'd2:    DAT_O = {4'd0, deb_q};
               default: DAT_O = {6'd0, ctrl_q};
            endcase
         end
      end
   end

   // Weight of sensor i is 20*i - 70, so the line centre sits between sensors 3 and 4.
   always_comb begin
      sum_c = '0;
      cnt_c = '0;
      for (int i = 0; i < 8; i++) begin
         if (filt_q[i]) begin
            sum_c = sum_c + 10'(20 * i - 70);
            cnt_c = cnt_c + 4'd1;
         end
      end
      mag_c = sum_c[9] ? 8'(-sum_c) : 8'(sum_c);
   end

   assign trial_c = {rem_q, quo_q[7]};
   assign s_c     = samp ^ {8{ctrl_q[1]}};
   assign acc_c   = samp_stb && ctrl_q[0];
   assign deb_eff = (deb_q == 4'd0) ? 4'd1 : deb_q;
   assign upd_c   = chk_q && (stab_q >= deb_eff) && (cand_q != filt_q);

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      filt_d    = filt_q;
      cand_d    = cand_q;
      stab_d    = stab_q;
      chk_d     = acc_c;
      pos_d     = pos_q;
      avail_d   = avail_q;
      deb_d     = deb_q;
      ctrl_d    = ctrl_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      step_d    = step_q;
      avail_set = 1'b0;

      if (acc_c) begin
         if (s_c == cand_q) begin
            stab_d = (stab_q == 4'd15) ? 4'd15 : stab_q + 4'd1;
         end else begin
            cand_d = s_c;
            stab_d = 4'd1;
         end
      end
      if (reg_wr && ADR_I[1:0] == 2'd2) begin
         deb_d  = DAT_I[3:0];
         stab_d = 4'd0;
      end
      if (reg_wr && ADR_I[1:0] == 2'd3) ctrl_d = DAT_I[1:0];
      if (upd_c) filt_d = cand_q;

      case (state_q)
         S_IDLE: begin
            if (req_q || upd_c) begin
               state_d = S_SUM;
               req_d   = 1'b0;
            end
         end
         S_SUM: begin
            quo_d   = mag_c;
            rem_d   = 4'd0;
            cnt_d   = cnt_c;
            neg_d   = sum_c[9];
            step_d  = 4'd0;
            state_d = S_DIV;
         end
         S_DIV: begin
            step_d = step_q + 4'd1;
            if (step_q == 4'd8) begin
               quo_d   = neg_q ? (~quo_q + 8'd1) : quo_q;
               state_d = S_DONE;
            end else if (trial_c >= {1'b0, cnt_q}) begin
               rem_d = 4'(trial_c - {1'b0, cnt_q});
               quo_d = {quo_q[6:0], 1'b1};
            end else begin
               rem_d = trial_c[3:0];
               quo_d = {quo_q[6:0], 1'b0};
            end
         end
         default: begin
            pos_d     = (cnt_q == 4'd0) ? 8'h80 : quo_q;
            avail_set = 1'b1;
            state_d   = S_IDLE;
         end
      endcase

      // A newer filtered value makes the running computation stale: drop it and rerun.
      if (state_q != S_IDLE && upd_c) begin
         state_d   = S_IDLE;
         req_d     = 1'b1;
         pos_d     = pos_q;
         avail_set = 1'b0;
      end

      if (reg_rd) avail_d = 1'b0;
      if (avail_set) avail_d = 1'b1;
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         filt_q  <= 8'h00;
         cand_q  <= 8'h00;
         stab_q  <= 4'd0;
         chk_q   <= 1'b0;
         pos_q   <= 8'h80;
         avail_q <= 1'b0;
         deb_q   <= 4'd1;
         ctrl_q  <= 2'b01;
         quo_q   <= 8'h00;
         rem_q   <= 4'd0;
         cnt_q   <= 4'd0;
         neg_q   <= 1'b0;
         step_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         filt_q  <= filt_d;
         cand_q  <= cand_d;
         stab_q  <= stab_d;
         chk_q   <= chk_d;
         pos_q   <= pos_d;
         avail_q <= avail_d;
         deb_q   <= deb_d;
         ctrl_q  <= ctrl_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         step_q  <= step_d;
      end
   end

endmodule

// File: doc/qtrline.md
QTRLINE -- requirements
Module: qtrline

Interface
REQ-001 Parameters: none; sensor count fixed at 8, register window fixed at 4 registers.
REQ-002 CLK_I  in  1  system clock; all logic on rising edge.
REQ-003 RST_I  in  1  synchronous, active-high reset.
REQ-004 WE_I  in  1  transfer direction; read=0, write=1.
REQ-005 TGA_I  in  1  1=register access, 0=autosend poll.
REQ-006 STB_I  in  1  peripheral selected.
REQ-007 ADR_I  in  8  register address.
REQ-008 DAT_I  in  8  bus data in.
REQ-009 samp_stb  in  1  one-cycle pulse from upstream QTR sampler: new sample valid.
REQ-010 samp  in  8  raw sample; 1=black.
REQ-011 STALL_O  out  1  constant 0.
REQ-012 ACK_O  out  1  equals myaddr = STB_I and ADR_I[7:2]==0, combinational.
REQ-013 DAT_O  out  8  bus data out; equals DAT_I when not myaddr.

Function
REQ-014 Registers: 0 position (signed 8-bit, read-only); 1 filtered bits (read-only); 2 debounce count [3:0] (RW); 3 control (RW; bit0 enable, bit1 invert).
REQ-015 DAT_O when myaddr: ~TGA_I and data_avail -> 0x02; ~TGA_I and not data_avail -> 0x00; TGA_I -> addressed register, unused bits 0.
REQ-016 Sample conditioning: s = samp XOR (invert ? 0xFF : 0x00); samp_stb ignored when enable=0.
REQ-017 Debounce on accepted strobe: s==cand -> stab = min(stab+1, 15); s!=cand -> cand<=s, stab<=1.
REQ-018 Effective threshold D = debounce reg, with 0 treated as 1; filtered<=cand on the cycle after the strobe where the new stab >= D and cand != filtered.
REQ-019 Write to reg 2 sets stab<=0; cand is kept.
REQ-020 A filtered change raises req; the position engine starts when in IDLE and req=1, clearing req.
REQ-021 Engine states: IDLE -> SUM (1 cycle) -> DIV (9 cycles) -> DONE (1 cycle) -> IDLE.
REQ-022 SUM latches an 8-bit snapshot of filtered; sum = sum over set bits i of (20*i - 70), 10-bit signed; cnt = popcount, 4 bits.
REQ-023 DIV: restoring division of |sum| by cnt, one quotient bit per cycle; quotient truncated toward zero, then negated if sum<0.
REQ-024 DONE: position <= (cnt==0) ? 0x80 : quotient[7:0] two's complement; data_avail <= 1.
REQ-025 Latency: position and data_avail update exactly 11 cycles after the filtered update when the engine is idle.
REQ-026 A filtered change while busy sets req; the engine restarts from IDLE on the next cycle using the latest filtered value; intermediate values are never reported.
REQ-027 Reads of reg 0 while busy return the previous position.
REQ-028 Any register read (TGA_I, myaddr, ~WE_I) clears data_avail; if set in DONE on the same cycle, set wins.
REQ-029 Range: position is in -70..+70 or 0x80; all 8 bits set -> 0x00.

Reset
REQ-030 RST_I=1 at any cycle, including mid-SUM/DIV, gives on the next edge:
- state IDLE, req 0
- filtered 0x00, cand 0x00, stab 0
- position 0x80, data_avail 0
- debounce 0x1, control 0x01 (enabled, no invert)
REQ-031 During and after reset, STALL_O=0; DAT_O and ACK_O obey REQ-012/013/015 with reset register values.

Verification
REQ-032 Reset, then samp_stb with samp=0x18 -> filtered 0x18; 11 cycles later position 0x00 and data_avail=1; poll returns 0x02.
REQ-033 Sign and truncation cases:
- samp 0x01 -> position 0xBA (-70)
- samp 0xC0 -> 0x3C (+60)
- samp 0x0B -> 0xD5 (-130/3 = -43, truncated)
- samp 0x00 -> 0x80
REQ-034 Debounce: debounce=3, strobes 0x01,0x01,0x02,0x02,0x02 -> filtered stays 0x00 through the 4th strobe, becomes 0x02 after the 5th; control bit1=1 with samp 0xFE -> filtered 0x01.
REQ-035 Busy overlap: strobe 0x01 then 0x80 three cycles later (D=1) -> single final report, position 0x46 (+70), with no 0xBA report.
REQ-036 Read clears data_avail (poll then returns 0x00); a read coinciding with DONE leaves data_avail=1.
REQ-037 RST_I asserted mid-DIV -> next cycle position 0x80, data_avail 0, debounce 0x1, control 0x01.
